// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - EX forwarding, ID stall/flush control and MDU in-flight scoreboard
module hazard_scoreboard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = 4,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] source_reg1_id,
  input  logic [REG_ADDR_W-1:0] source_reg2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic                  md_op_id,
  input  logic [REG_ADDR_W-1:0] source_reg1_ex,
  input  logic [REG_ADDR_W-1:0] source_reg2_ex,
  input  logic [REG_ADDR_W-1:0] reg_dest_ex,
  input  logic                  result_src_ex,
  input  logic                  md_start_ex,
  input  logic [REG_ADDR_W-1:0] reg_dest_mem,
  input  logic                  reg_write_mem,
  input  logic [REG_ADDR_W-1:0] reg_dest_wb,
  input  logic                  reg_write_wb,
  input  logic                  pc_src_ex,
  output logic [1:0]            forward_ae,
  output logic [1:0]            forward_be,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [REG_ADDR_W-1:0] md_rd,
  output logic [PERF_W-1:0]     stall_cnt,
  output logic [PERF_W-1:0]     flush_cnt
);

  localparam int CNT_W = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

  md_state_t             r_state;
  md_state_t             w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [REG_ADDR_W-1:0] r_md_rd;
  logic [REG_ADDR_W-1:0] w_md_rd_nxt;
  logic [PERF_W-1:0]     r_stall_cnt;
  logic [PERF_W-1:0]     r_flush_cnt;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_md_busy;
  logic       w_md_done;
  logic       w_md_pending;
  logic       w_ex_match;
  logic       w_md_match;
  logic       w_ld_hz;
  logic       w_mdx_hz;
  logic       w_mdp_hz;
  logic       w_mds_hz;
  logic       w_stall;

  // MEM result is younger than WB, so it wins when both target the same register
  always_comb begin
    w_fwd_a = 2'b00;
    if (source_reg1_ex != '0 && reg_write_mem && source_reg1_ex == reg_dest_mem) begin
      w_fwd_a = 2'b10;
    end else if (source_reg1_ex != '0 && reg_write_wb && source_reg1_ex == reg_dest_wb) begin
      w_fwd_a = 2'b01;
    end
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (source_reg2_ex != '0 && reg_write_mem && source_reg2_ex == reg_dest_mem) begin
      w_fwd_b = 2'b10;
    end else if (source_reg2_ex != '0 && reg_write_wb && source_reg2_ex == reg_dest_wb) begin
      w_fwd_b = 2'b01;
    end
  end

  assign w_md_busy    = (r_state == ST_BUSY);
  assign w_md_done    = w_md_busy && (r_cnt == '0);
  assign w_md_pending = w_md_busy && !w_md_done;

  assign w_ex_match = (reg_dest_ex != '0) &&
                      ((rs1_used_id && source_reg1_id == reg_dest_ex) ||
                       (rs2_used_id && source_reg2_id == reg_dest_ex));
  assign w_md_match = (r_md_rd != '0) &&
                      ((rs1_used_id && source_reg1_id == r_md_rd) ||
                       (rs2_used_id && source_reg2_id == r_md_rd));

  assign w_ld_hz  = result_src_ex && w_ex_match;
  assign w_mdx_hz = md_start_ex && w_ex_match;
  // The done cycle releases dependents: the regfile writes through to ID
  assign w_mdp_hz = w_md_pending && w_md_match;
  assign w_mds_hz = md_op_id && (w_md_pending || md_start_ex);

  // A taken branch discards the ID instruction, so there is nothing to hold
  assign w_stall = (w_ld_hz || w_mdx_hz || w_mdp_hz || w_mds_hz) && !pc_src_ex;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_md_rd_nxt = r_md_rd;
    case (r_state)
      ST_IDLE: begin
        if (md_start_ex) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CNT_LOAD;
          w_md_rd_nxt = reg_dest_ex;
        end
      end
      ST_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (md_start_ex) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CNT_LOAD;
          w_md_rd_nxt = reg_dest_ex;
        end else begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_md_rd_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_md_rd_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_md_rd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_md_rd <= w_md_rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      end
      if (pc_src_ex && r_flush_cnt != '1) begin
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      end
    end
  end

  assign forward_ae = rst ? 2'b00 : w_fwd_a;
  assign forward_be = rst ? 2'b00 : w_fwd_b;
  assign stall_if   = !rst && w_stall;
  assign stall_id   = !rst && w_stall;
  assign flush_id   = !rst && pc_src_ex;
  assign flush_ex   = !rst && (w_stall || pc_src_ex);
  assign md_busy    = !rst && w_md_busy;
  assign md_done    = !rst && w_md_done;
  assign md_rd      = rst ? '0 : r_md_rd;
  assign stall_cnt  = rst ? '0 : r_stall_cnt;
  assign flush_cnt  = rst ? '0 : r_flush_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - vector table, corner sequences and random run against a timestamp model
module tb_hazard_scoreboard_unit;

  localparam int AW  = 5;
  localparam int MDL = 4;
  localparam int PW  = 4;
  localparam int SAT = (1 << PW) - 1;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] rs1_id;
    logic [AW-1:0] rs2_id;
    logic          u1;
    logic          u2;
    logic          md_op;
    logic [AW-1:0] rs1_ex;
    logic [AW-1:0] rs2_ex;
    logic [AW-1:0] rd_ex;
    logic          load;
    logic          md_start;
    logic [AW-1:0] rd_mem;
    logic          wm;
    logic [AW-1:0] rd_wb;
    logic          ww;
    logic          pc_src;
  } in_t;

  typedef struct {
    in_t        i;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       fl;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [AW-1:0] source_reg1_id, source_reg2_id;
  logic          rs1_used_id, rs2_used_id, md_op_id;
  logic [AW-1:0] source_reg1_ex, source_reg2_ex, reg_dest_ex;
  logic          result_src_ex, md_start_ex;
  logic [AW-1:0] reg_dest_mem, reg_dest_wb;
  logic          reg_write_mem, reg_write_wb, pc_src_ex;
  logic [1:0]    forward_ae, forward_be;
  logic          stall_if, stall_id, flush_id, flush_ex;
  logic          md_busy, md_done;
  logic [AW-1:0] md_rd;
  logic [PW-1:0] stall_cnt, flush_cnt;

  hazard_scoreboard_unit #(.REG_ADDR_W(AW), .MD_LATENCY(MDL), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .source_reg1_id(source_reg1_id), .source_reg2_id(source_reg2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .md_op_id(md_op_id),
    .source_reg1_ex(source_reg1_ex), .source_reg2_ex(source_reg2_ex),
    .reg_dest_ex(reg_dest_ex), .result_src_ex(result_src_ex), .md_start_ex(md_start_ex),
    .reg_dest_mem(reg_dest_mem), .reg_write_mem(reg_write_mem),
    .reg_dest_wb(reg_dest_wb), .reg_write_wb(reg_write_wb), .pc_src_ex(pc_src_ex),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .md_busy(md_busy), .md_done(md_done), .md_rd(md_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an MDU op is a timestamp; it is busy for MDL cycles after its issue cycle
  int          cyc = 0;
  bit          m_valid = 1'b0;
  int          m_issue = 0;
  logic [AW-1:0] m_rd = '0;
  int          m_scnt = 0;
  int          m_fcnt = 0;
  bit          e_stall, e_busy, e_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply(input in_t v);
    rst            = v.rst;
    source_reg1_id = v.rs1_id;
    source_reg2_id = v.rs2_id;
    rs1_used_id    = v.u1;
    rs2_used_id    = v.u2;
    md_op_id       = v.md_op;
    source_reg1_ex = v.rs1_ex;
    source_reg2_ex = v.rs2_ex;
    reg_dest_ex    = v.rd_ex;
    result_src_ex  = v.load;
    md_start_ex    = v.md_start;
    reg_dest_mem   = v.rd_mem;
    reg_write_mem  = v.wm;
    reg_dest_wb    = v.rd_wb;
    reg_write_wb   = v.ww;
    pc_src_ex      = v.pc_src;
  endtask

  function automatic bit uses(input logic [AW-1:0] r);
    return (rs1_used_id && source_reg1_id == r) || (rs2_used_id && source_reg2_id == r);
  endfunction

  function automatic int fwd(input logic [AW-1:0] s);
    if (s != 0 && reg_write_mem && s == reg_dest_mem) return 2;
    if (s != 0 && reg_write_wb && s == reg_dest_wb) return 1;
    return 0;
  endfunction

  task automatic settle_check();
    int  age;
    bit  hz;
    #1;
    age    = cyc - m_issue;
    e_busy = m_valid && age >= 1 && age <= MDL;
    e_done = e_busy && age == MDL;
    hz = (result_src_ex && reg_dest_ex != 0 && uses(reg_dest_ex)) ||
         (md_start_ex && reg_dest_ex != 0 && uses(reg_dest_ex)) ||
         (e_busy && !e_done && m_rd != 0 && uses(m_rd)) ||
         (md_op_id && ((e_busy && !e_done) || md_start_ex));
    e_stall = hz && !pc_src_ex;
    if (rst) begin
      chk("rst_forward_ae", 32'(forward_ae), 0);
      chk("rst_forward_be", 32'(forward_be), 0);
      chk("rst_stall_if", 32'(stall_if), 0);
      chk("rst_flush_ex", 32'(flush_ex), 0);
      chk("rst_flush_id", 32'(flush_id), 0);
      chk("rst_md_busy", 32'(md_busy), 0);
      chk("rst_md_done", 32'(md_done), 0);
      chk("rst_md_rd", 32'(md_rd), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      chk("rst_flush_cnt", 32'(flush_cnt), 0);
    end else begin
      chk("forward_ae", 32'(forward_ae), 32'(fwd(source_reg1_ex)));
      chk("forward_be", 32'(forward_be), 32'(fwd(source_reg2_ex)));
      chk("stall_if", 32'(stall_if), 32'(e_stall));
      chk("stall_id", 32'(stall_id), 32'(e_stall));
      chk("flush_id", 32'(flush_id), 32'(pc_src_ex));
      chk("flush_ex", 32'(flush_ex), 32'(e_stall || pc_src_ex));
      chk("md_busy", 32'(md_busy), 32'(e_busy));
      chk("md_done", 32'(md_done), 32'(e_done));
      chk("md_rd", 32'(md_rd), e_busy ? 32'(m_rd) : 0);
      chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    end
  endtask

  task automatic advance();
    if (rst) begin
      m_valid = 1'b0;
      m_scnt  = 0;
      m_fcnt  = 0;
    end else begin
      if (e_stall && m_scnt < SAT) m_scnt++;
      if (pc_src_ex && m_fcnt < SAT) m_fcnt++;
      if (md_start_ex && (!e_busy || e_done)) begin
        m_valid = 1'b1;
        m_issue = cyc;
        m_rd    = reg_dest_ex;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input in_t v);
    apply(v);
    settle_check();
    advance();
  endtask

  task automatic do_reset();
    in_t v;
    v     = '0;
    v.rst = 1'b1;
    step(v);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t e;
    in_t  v;

    e = '{i: '0, fa: 2'b10, fb: 2'b00, st: 1'b0, fl: 1'b0};
    e.i.rs1_ex = 5; e.i.rd_mem = 5; e.i.wm = 1; e.i.rd_wb = 5; e.i.ww = 1; tbl.push_back(e);
    e.i.rs1_ex = 0; e.fa = 2'b00; tbl.push_back(e);
    e = '{i: '0, fa: 2'b01, fb: 2'b01, st: 1'b0, fl: 1'b0};
    e.i.rs1_ex = 6; e.i.rs2_ex = 6; e.i.rd_mem = 6; e.i.rd_wb = 6; e.i.ww = 1; tbl.push_back(e);
    e = '{i: '0, fa: 2'b01, fb: 2'b10, st: 1'b0, fl: 1'b0};
    e.i.rs1_ex = 4; e.i.rs2_ex = 3; e.i.rd_mem = 3; e.i.wm = 1; e.i.rd_wb = 4; e.i.ww = 1; tbl.push_back(e);
    e = '{i: '0, fa: 2'b00, fb: 2'b00, st: 1'b1, fl: 1'b0};
    e.i.load = 1; e.i.rd_ex = 7; e.i.rs2_id = 7; e.i.u2 = 1; tbl.push_back(e);
    e.i.u2 = 0; e.st = 1'b0; tbl.push_back(e);
    e = '{i: '0, fa: 2'b00, fb: 2'b00, st: 1'b0, fl: 1'b0};
    e.i.load = 1; e.i.rd_ex = 0; e.i.rs1_id = 0; e.i.u1 = 1; tbl.push_back(e);
    e = '{i: '0, fa: 2'b00, fb: 2'b00, st: 1'b0, fl: 1'b1};
    e.i.load = 1; e.i.rd_ex = 7; e.i.rs1_id = 7; e.i.u1 = 1; e.i.pc_src = 1; tbl.push_back(e);
    e = '{i: '0, fa: 2'b00, fb: 2'b00, st: 1'b0, fl: 1'b0};
    e.i.md_op = 1; tbl.push_back(e);
    e = '{i: '0, fa: 2'b00, fb: 2'b00, st: 1'b0, fl: 1'b0};
    e.i.rs1_ex = 5; e.i.rd_mem = 5; e.i.wm = 0; tbl.push_back(e);

    v = '0; v.rst = 1'b1; apply(v);
    @(posedge clk);
    #1;
    v = '0; v.rst = 1'b1; v.rs1_ex = 5; v.rd_mem = 5; v.wm = 1; v.load = 1; v.rd_ex = 7;
    v.rs1_id = 7; v.u1 = 1; v.pc_src = 1;
    step(v);
    v = '0;
    apply(v); settle_check();
    chk("reset_md_busy", 32'(md_busy), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    advance();

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i);
      settle_check();
      chk($sformatf("tbl%0d_fa", k), 32'(forward_ae), 32'(tbl[k].fa));
      chk($sformatf("tbl%0d_fb", k), 32'(forward_be), 32'(tbl[k].fb));
      chk($sformatf("tbl%0d_stall", k), 32'(stall_if), 32'(tbl[k].st));
      chk($sformatf("tbl%0d_flush_ex", k), 32'(flush_ex), 32'(tbl[k].st | tbl[k].fl));
      chk($sformatf("tbl%0d_flush_id", k), 32'(flush_id), 32'(tbl[k].fl));
      advance();
    end

    // MDU result dependency: stall through the busy cycles, released on md_done
    do_reset();
    v = '0; v.md_start = 1; v.rd_ex = 9; v.rs1_id = 9; v.u1 = 1;
    apply(v); settle_check();
    chk("mdx_stall", 32'(stall_if), 1);
    advance();
    v = '0; v.rs1_id = 9; v.u1 = 1;
    for (int k = 1; k <= MDL; k++) begin
      apply(v); settle_check();
      chk($sformatf("mdp_busy%0d", k), 32'(md_busy), 1);
      chk($sformatf("mdp_done%0d", k), 32'(md_done), (k == MDL) ? 1 : 0);
      chk($sformatf("mdp_stall%0d", k), 32'(stall_if), (k < MDL) ? 1 : 0);
      chk($sformatf("mdp_rd%0d", k), 32'(md_rd), 9);
      advance();
    end
    apply(v); settle_check();
    chk("mdp_idle", 32'(md_busy), 0);
    chk("mdp_rd_clear", 32'(md_rd), 0);
    chk("mdp_stall_cnt", 32'(stall_cnt), 4);
    advance();

    // Structural conflict and back-to-back issue on the done cycle
    do_reset();
    v = '0; v.md_start = 1; v.rd_ex = 10; step(v);
    v = '0; v.md_op = 1;
    for (int k = 1; k < MDL; k++) begin
      apply(v); settle_check();
      chk($sformatf("mds_stall%0d", k), 32'(stall_if), 1);
      advance();
    end
    v = '0; v.md_start = 1; v.rd_ex = 11;
    apply(v); settle_check();
    chk("b2b_done", 32'(md_done), 1);
    chk("b2b_nostall", 32'(stall_if), 0);
    advance();
    v = '0;
    apply(v); settle_check();
    chk("b2b_busy", 32'(md_busy), 1);
    chk("b2b_rd", 32'(md_rd), 11);
    chk("b2b_not_done", 32'(md_done), 0);
    advance();
    for (int k = 0; k < MDL; k++) step(v);

    // Load-use coinciding with a taken branch
    do_reset();
    v = '0; v.load = 1; v.rd_ex = 7; v.rs1_id = 7; v.u1 = 1; v.pc_src = 1;
    apply(v); settle_check();
    chk("br_stall", 32'(stall_if), 0);
    chk("br_flush_id", 32'(flush_id), 1);
    chk("br_flush_ex", 32'(flush_ex), 1);
    advance();
    v = '0;
    apply(v); settle_check();
    chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 0);
    advance();

    // Counter saturation
    do_reset();
    v = '0; v.load = 1; v.rd_ex = 7; v.rs1_id = 7; v.u1 = 1;
    for (int k = 0; k < SAT + 2; k++) step(v);
    apply(v); settle_check();
    chk("sat_stall_cnt", 32'(stall_cnt), SAT);
    advance();
    v = '0;
    apply(v); settle_check();
    chk("sat_hold", 32'(stall_cnt), SAT);
    advance();

    // Reset while an MDU op is in flight
    do_reset();
    v = '0; v.md_start = 1; v.rd_ex = 12; v.rs1_id = 12; v.u1 = 1; v.pc_src = 1; step(v);
    v = '0; v.rs1_id = 12; v.u1 = 1; step(v); step(v);
    v.rst = 1'b1;
    apply(v); settle_check();
    chk("mid_rst_busy", 32'(md_busy), 0);
    advance();
    v = '0;
    for (int k = 0; k < 3; k++) begin
      apply(v); settle_check();
      chk($sformatf("post_rst_busy%0d", k), 32'(md_busy), 0);
      chk($sformatf("post_rst_done%0d", k), 32'(md_done), 0);
      chk($sformatf("post_rst_scnt%0d", k), 32'(stall_cnt), 0);
      chk($sformatf("post_rst_fcnt%0d", k), 32'(flush_cnt), 0);
      advance();
    end

    // Random traffic on a small register range to provoke matches
    for (int n = 0; n < 600; n++) begin
      v          = '0;
      v.rst      = ($urandom_range(0, 79) == 0);
      v.rs1_id   = 5'($urandom_range(0, 3));
      v.rs2_id   = 5'($urandom_range(0, 3));
      v.u1       = 1'($urandom_range(0, 1));
      v.u2       = 1'($urandom_range(0, 1));
      v.md_op    = ($urandom_range(0, 3) == 0);
      v.rs1_ex   = 5'($urandom_range(0, 3));
      v.rs2_ex   = 5'($urandom_range(0, 3));
      v.rd_ex    = 5'($urandom_range(0, 3));
      v.load     = ($urandom_range(0, 2) == 0);
      v.md_start = ($urandom_range(0, 4) == 0);
      v.rd_mem   = 5'($urandom_range(0, 3));
      v.wm       = 1'($urandom_range(0, 1));
      v.rd_wb    = 5'($urandom_range(0, 3));
      v.ww       = 1'($urandom_range(0, 1));
      v.pc_src   = ($urandom_range(0, 7) == 0);
      step(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Pipeline hazard controller for the 5-stage RV32 core, extended for a multi-cycle mul/div unit (MDU).
- Generates EX-stage operand forwarding selects.
- Detects load-use and MDU-result dependencies, plus MDU structural conflicts, and stalls IF/ID with an EX bubble.
- Flushes on taken branch/jump.
- Tracks the in-flight MDU op with an internal busy FSM and keeps saturating stall/flush performance counters.

Parameters:
REG_ADDR_W, 5, register index width
MD_LATENCY, 4, MDU cycles from issue to result write (legal range 2..16)
PERF_W, 32, performance counter width

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
source_reg1_id  input  REG_ADDR_W  rs1 of instruction in ID
source_reg2_id  input  REG_ADDR_W  rs2 of instruction in ID
rs1_used_id  input  1  ID instruction reads rs1
rs2_used_id  input  1  ID instruction reads rs2
md_op_id  input  1  ID instruction is an MDU op
source_reg1_ex  input  REG_ADDR_W  rs1 in EX
source_reg2_ex  input  REG_ADDR_W  rs2 in EX
reg_dest_ex  input  REG_ADDR_W  rd in EX
result_src_ex  input  1  EX instruction is a load
md_start_ex  input  1  MDU op issuing from EX this cycle
reg_dest_mem  input  REG_ADDR_W  rd in MEM
reg_write_mem  input  1  MEM writes rd
reg_dest_wb  input  REG_ADDR_W  rd in WB
reg_write_wb  input  1  WB writes rd
pc_src_ex  input  1  taken branch/jump resolved in EX
forward_ae  output  2  rs1 EX select: 00 regfile, 01 WB, 10 MEM
forward_be  output  2  rs2 EX select, same encoding
stall_if  output  1  hold PC
stall_id  output  1  hold IF/ID register
flush_id  output  1  clear IF/ID register
flush_ex  output  1  clear ID/EX register (bubble)
md_busy  output  1  MDU op in flight
md_done  output  1  MDU result written this cycle
md_rd  output  REG_ADDR_W  destination of in-flight MDU op
stall_cnt  output  PERF_W  cycles with stall_if asserted
flush_cnt  output  PERF_W  cycles with flush_id asserted

Behaviour:
Forwarding (combinational):
- MEM match has priority over WB. A match requires equal index, the corresponding reg_write, and source != 0.
- x0 is never forwarded.

Stall causes (combinational, ID-side):
- ld_hz = result_src_ex & reg_dest_ex != 0 & ((rs1_used_id & source_reg1_id == reg_dest_ex) | (rs2_used_id & source_reg2_id == reg_dest_ex)).
- mdx_hz: same comparison against reg_dest_ex, gated by md_start_ex instead of result_src_ex.
- mdp_hz = md_busy & !md_done & md_rd != 0 & ID uses a source equal to md_rd.
- mds_hz = md_op_id & ((md_busy & !md_done) | md_start_ex); structural, one MDU op in flight.
- stall = (ld_hz | mdx_hz | mdp_hz | mds_hz) & !pc_src_ex. A flush overrides a stall because the ID instruction is being discarded.

Output equations:
- stall_if = stall_id = stall.
- flush_ex = stall | pc_src_ex.
- flush_id = pc_src_ex.

MDU FSM (registered):
- States: IDLE, BUSY.
- IDLE + md_start_ex -> BUSY; cnt <= MD_LATENCY-1; md_rd <= reg_dest_ex.
- BUSY, cnt != 0: cnt <= cnt-1.
- BUSY, cnt == 0: md_done = 1 (combinational from state), next state IDLE, md_rd <= 0.
- md_start_ex while BUSY and cnt == 0: go directly to BUSY with the new cnt/md_rd (back-to-back issue).
- md_start_ex while BUSY and cnt != 0: cannot occur, because mds_hz prevents it; if it does occur it is ignored.
- A dependency on md_rd is released in the md_done cycle; the regfile is write-through.
- pc_src_ex does not cancel an in-flight MDU op, since that op is older than the branch.
- md_busy = (state == BUSY).

Performance counters:
- stall_cnt increments on each cycle with stall = 1; flush_cnt increments on each cycle with pc_src_ex = 1.
- Both saturate at all-ones and do not wrap.

Reset:
- rst is sampled on the clk rising edge: state IDLE, cnt 0, md_rd 0, stall_cnt 0, flush_cnt 0.
- While rst = 1, all outputs are forced to 0.
- Reset mid-MDU op abandons it; md_done is not asserted.

Test Plan:
- MEM rd=5 write, WB rd=5 write, EX rs1=5 -> forward_ae=10. Same with rs1=0 -> forward_ae=00.
- Load in EX rd=7; ID rs2=7, rs2_used=1 -> stall_if=stall_id=flush_ex=1 for one cycle. With rs2_used=0 -> no stall.
- MD_LATENCY=4, md_start_ex rd=9; next ID reads x9 -> md_busy high 4 cycles, md_done on the 4th. Stall held through cycle 3, released in the md_done cycle. stall_cnt advances accordingly.
- MDU busy, ID md_op_id=1 -> structural stall until the md_done cycle. In that cycle the op issues and the FSM re-enters BUSY with no IDLE gap.
- Load-use hazard and pc_src_ex=1 in the same cycle -> stall=0, flush_id=flush_ex=1, flush_cnt +1, stall_cnt unchanged.
- Force stall_cnt to all-ones (PERF_W=4 build, 15 stalls) -> stays 15. rst asserted mid-BUSY -> md_busy=0 and counters=0 next cycle.
